// File: rtl/bc_bo_pkg.sv
// Shared definitions between the BC control FSM and the bo_datapath operative block.
// The strobe bundle ctrl_t is the single definition of what BC drives into the datapath.
package bc_bo_pkg;

    localparam int BC_STATE_W = 3;

    typedef enum logic [BC_STATE_W-1:0] {
        BC_A = 3'd0,
        BC_B = 3'd1,
        BC_C = 3'd2,
        BC_D = 3'd3,
        BC_E = 3'd4,
        BC_F = 3'd5
    } bc_state_t;

    typedef struct packed {
        logic lx;
        logic ls;
        logic lh;
        logic h;
        logic lr;
    } ctrl_t;

endpackage

// File: rtl/dp_reg.sv
// Enabled register with asynchronous active-low clear; one instance per datapath register.
module dp_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/bo_datapath.sv
// Repeated-addition multiplier datapath (S = X * N) steered by BC strobes.
// h selects initial values (1) or one accumulate/decrement step (0).
module bo_datapath
    import bc_bo_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int CWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  x_in,
    input  logic [CWIDTH-1:0] n_in,
    input  logic              lx,
    input  logic              ls,
    input  logic              lh,
    input  logic              h,
    input  logic              lr,
    output logic              h_zero,
    output logic              s_ovf,
    output logic [WIDTH-1:0]  result,
    output logic              r_valid
);

    ctrl_t             ctrl;
    logic [WIDTH-1:0]  x_q;
    logic [WIDTH-1:0]  s_q;
    logic [WIDTH-1:0]  s_d;
    logic [CWIDTH-1:0] h_q;
    logic [CWIDTH-1:0] h_d;
    logic [WIDTH:0]    sum;
    logic              ovf_q;
    logic              ovf_d;
    logic              r_valid_q;

    assign ctrl = '{lx: lx, ls: ls, lh: lh, h: h, lr: lr};

    // The counter floors at zero so a stray step after completion cannot wrap.
    always_comb begin
        sum   = {1'b0, s_q} + {1'b0, x_q};
        s_d   = ctrl.h ? '0 : sum[WIDTH-1:0];
        ovf_d = ctrl.h ? 1'b0 : (ovf_q | sum[WIDTH]);
        if (ctrl.h) begin
            h_d = n_in;
        end else if (h_q != '0) begin
            h_d = h_q - CWIDTH'(1);
        end else begin
            h_d = '0;
        end
    end

    dp_reg #(.W(WIDTH))  u_x (.clk(clk), .rst_n(rst_n), .en(ctrl.lx), .d(x_in), .q(x_q));
    dp_reg #(.W(WIDTH))  u_s (.clk(clk), .rst_n(rst_n), .en(ctrl.ls), .d(s_d),  .q(s_q));
    dp_reg #(.W(CWIDTH)) u_h (.clk(clk), .rst_n(rst_n), .en(ctrl.lh), .d(h_d),  .q(h_q));
    dp_reg #(.W(WIDTH))  u_r (.clk(clk), .rst_n(rst_n), .en(ctrl.lr), .d(s_q),  .q(result));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q     <= 1'b0;
            r_valid_q <= 1'b0;
        end else begin
            if (ctrl.ls) begin
                ovf_q <= ovf_d;
            end
            r_valid_q <= ctrl.lr;
        end
    end

    // Pure register decode, so BC never sees a path from its own strobes back to its inputs.
    assign h_zero  = (h_q == '0);
    assign s_ovf   = ovf_q;
    assign r_valid = r_valid_q;

endmodule

// File: tb/tb_bo_datapath.sv
// Scoreboard bench for bo_datapath: arithmetic reference model, expected results queued on lr.
module tb_bo_datapath;

    logic       clk;
    logic       rst_n;
    logic [7:0] x_in;
    logic [7:0] n_in;
    logic       lx, ls, lh, h, lr;
    logic       h_zero;
    logic       s_ovf;
    logic [7:0] result;
    logic       r_valid;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int res;
        int ovf;
    } exp_t;

    exp_t exp_q[$];

    // reference model state (plain integers)
    int mx, ms, mh, movf;

    bo_datapath #(.WIDTH(8), .CWIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .x_in(x_in), .n_in(n_in),
        .lx(lx), .ls(ls), .lh(lh), .h(h), .lr(lr),
        .h_zero(h_zero), .s_ovf(s_ovf), .result(result), .r_valid(r_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mx = 0; ms = 0; mh = 0; movf = 0;
        exp_q.delete();
    endtask

    // Drive one cycle of strobes, advance the model at the edge, check status after it.
    task automatic step(input logic ilx, input logic ils, input logic ilh,
                        input logic ih, input logic ilr,
                        input int ix, input int in_n);
        int   old_s;
        int   t;
        exp_t e;
        @(negedge clk);
        lx = ilx; ls = ils; lh = ilh; h = ih; lr = ilr;
        x_in = 8'(ix); n_in = 8'(in_n);
        @(posedge clk);
        old_s = ms;
        if (ils) begin
            if (ih) begin
                ms = 0; movf = 0;
            end else begin
                t = ms + mx;
                if (t > 255) movf = 1;
                ms = t % 256;
            end
        end
        if (ilx) mx = ix;
        if (ilh) begin
            if (ih) mh = in_n;
            else if (mh > 0) mh = mh - 1;
        end
        if (ilr) begin
            e.res = old_s; e.ovf = movf;
            exp_q.push_back(e);
        end
        #1;
        chk("h_zero", int'(h_zero), (mh == 0) ? 1 : 0);
        chk("s_ovf", int'(s_ovf), movf);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_step();
        logic [4:0] r;
        r = 5'($urandom);
        step(r[0], r[1], r[2], r[3], r[4], int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
    endtask

    // Full multiply sequence as BC would issue it; checks the step count equals n.
    task automatic multiply(input int x, input int n);
        int steps;
        step(1, 1, 1, 1, 0, x, n);
        steps = 0;
        while (!h_zero && steps < 300) begin
            step(0, 1, 1, 0, 0, 0, 0);
            steps++;
        end
        chk("mult_steps", steps, n);
        step(0, 0, 0, 0, 1, 0, 0);
        idle();
    endtask

    // Monitor: every r_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && r_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_r_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("result", int'(result), e.res);
                chk("result_ovf", int'(s_ovf), e.ovf);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        lx = 0; ls = 0; lh = 0; h = 0; lr = 0; x_in = 0; n_in = 0;
        model_reset();

        // 1: reset with random strobes
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            {lx, ls, lh, h, lr} = 5'($urandom);
            x_in = 8'($urandom); n_in = 8'($urandom);
        end
        #1;
        chk("rst_h_zero", int'(h_zero), 1);
        chk("rst_s_ovf", int'(s_ovf), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_r_valid", int'(r_valid), 0);
        @(negedge clk);
        lx = 0; ls = 0; lh = 0; h = 0; lr = 0;
        rst_n = 1'b1;
        step(0, 0, 0, 0, 1, 0, 0);   // result <- S (0)
        step(0, 1, 0, 0, 0, 0, 0);   // S <- S + X with X = 0
        step(0, 0, 0, 0, 1, 0, 0);
        idle();

        // 2: 7 * 5
        multiply(7, 5);
        chk("mult_7x5_result", int'(result), 35);

        // 3: overflow, then clear by reload
        multiply(100, 3);
        chk("ovf_result", int'(result), 44);
        chk("ovf_flag", int'(s_ovf), 1);
        step(0, 1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        idle();

        // 4: H floor at zero
        step(0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0);

        // 5: simultaneous lx/ls and lr/ls
        step(1, 1, 1, 1, 0, 10, 1);
        step(0, 1, 1, 0, 0, 0, 0);    // S = 10
        step(1, 0, 0, 0, 0, 3, 0);    // X = 3
        step(1, 1, 0, 0, 0, 9, 0);    // S = 13 with old X, X = 9
        step(0, 1, 0, 0, 1, 0, 0);    // result = 13, S = 22
        step(0, 0, 0, 0, 1, 0, 0);    // result = 22
        step(0, 0, 0, 0, 1, 0, 0);    // back-to-back pulse
        idle();

        // 6: reset mid-run at H == 2
        step(1, 1, 1, 1, 0, 4, 5);
        while (mh > 2) step(0, 1, 1, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_h_zero", int'(h_zero), 1);
        chk("midrst_result", int'(result), 0);
        chk("midrst_s_ovf", int'(s_ovf), 0);
        chk("midrst_r_valid", int'(r_valid), 0);
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            {lx, ls, lh, h, lr} = 5'($urandom);
        end
        @(negedge clk);
        lx = 0; ls = 0; lh = 0; h = 0; lr = 0;
        rst_n = 1'b1;
        step(0, 1, 1, 0, 1, 0, 0);
        idle();

        // random multiplies with random noise cycles in between
        for (int k = 0; k < 30; k++) begin
            multiply(int'($urandom_range(0, 255)), int'($urandom_range(0, 12)));
            for (int j = 0; j < int'($urandom_range(0, 6)); j++) rand_step();
        end
        for (int j = 0; j < 200; j++) rand_step();

        idle();
        idle();
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
